// File: rtl/io_sync_fifo_pkg.sv
// Shared io_hub FIFO definitions: default sizing and the per-cycle pointer operation.
package io_sync_fifo_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_AW       = 2;
    localparam int DEF_AE_LEVEL = 1;

    // What the pointers do on a given edge; bit 0 = push, bit 1 = pop.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_XCHG = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/io_sync_fifo_if.sv
// Handshake/data bundle between a producer/consumer (master) and the FIFO (slave).
interface io_sync_fifo_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/io_fifo_ram.sv
// FIFO storage: 2**AW x WIDTH, synchronous write, asynchronous read.
module io_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is not reset; the pointers alone decide which words are live.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO using the full 2**AW depth, with count, almost flags,
// sticky overflow/underflow, synchronous flush and optional FWFT read.
module io_sync_fifo
    import io_sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AW       = DEF_AW,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = (1 << AW) - 1,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input logic           clk_i,
    input logic           rst_ni,
    io_sync_fifo_if.slave bus_s
);
    localparam logic [AW:0] AF_W    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_W    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             empty, full;
    logic             rd_ok, wr_ok;
    logic [AW:0]      count;
    logic [WIDTH-1:0] ram_rdata;
    fifo_op_e         op;

    // Status comes from registered pointers only, never from this cycle's requests.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A read needs stored data; a write into a full FIFO rides on a same-cycle read.
    assign rd_ok = bus_s.rd_en & ~empty;
    assign wr_ok = bus_s.wr_en & (~full | rd_ok);
    assign op    = fifo_op(wr_ok, rd_ok);

    // Next-state for pointers and sticky error flags; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus_s.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            case (op)
                FIFO_PUSH: wr_ptr_d = wr_ptr_q + PTR_ONE;
                FIFO_POP:  rd_ptr_d = rd_ptr_q + PTR_ONE;
                FIFO_XCHG: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: ;
            endcase
            ovf_d = ovf_q | (bus_s.wr_en & ~wr_ok);
            udf_d = udf_q | (bus_s.rd_en & empty);
        end
    end

    // Pointer and flag registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Memory is only touched by an accepted write outside reset/flush.
    io_fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_ok & ~bus_s.flush & rst_ni),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus_s.din),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible directly; meaningless while empty.
            assign bus_s.dout = ram_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;

            // Capture the head word on an accepted read; flush leaves dout alone.
            always_comb begin
                dout_d = dout_q;
                if (rd_ok && !bus_s.flush) dout_d = ram_rdata;
            end

            // Registered read data, cleared only by reset.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) dout_q <= '0;
                else         dout_q <= dout_d;
            end

            assign bus_s.dout = dout_q;
        end
    endgenerate

    assign bus_s.empty        = empty;
    assign bus_s.full         = full;
    assign bus_s.count        = count;
    assign bus_s.almost_full  = (count >= AF_W);
    assign bus_s.almost_empty = (count <= AE_W);
    assign bus_s.overflow     = ovf_q;
    assign bus_s.underflow    = udf_q;

endmodule

// File: tb/tb_io_sync_fifo.sv
// Directed bench for io_sync_fifo: a standard-read and an FWFT instance share
// stimulus and are compared every cycle against a queue-based model.
module tb_io_sync_fifo;
    localparam int WIDTH = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush, wr_en, rd_en;
    logic [WIDTH-1:0] din;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_sync_fifo_if #(.WIDTH(WIDTH), .AW(AW)) if0 ();
    io_sync_fifo_if #(.WIDTH(WIDTH), .AW(AW)) if1 ();

    assign if0.flush = flush;
    assign if0.wr_en = wr_en;
    assign if0.din   = din;
    assign if0.rd_en = rd_en;
    assign if1.flush = flush;
    assign if1.wr_en = wr_en;
    assign if1.din   = din;
    assign if1.rd_en = rd_en;

    io_sync_fifo #(.WIDTH(WIDTH), .AW(AW), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut0 (.clk_i(clk), .rst_ni(rst_n), .bus_s(if0));
    io_sync_fifo #(.WIDTH(WIDTH), .AW(AW), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .bus_s(if1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus sticky flags.
    logic [WIDTH-1:0] mq[$];
    bit               movf, mudf, live;
    logic [WIDTH-1:0] mdout;

    always @(posedge clk) begin
        bit rd, wr;
        live <= 1'b1;
        if (!rst_n) begin
            mq.delete();
            movf  = 0;
            mudf  = 0;
            mdout = '0;
        end else if (flush) begin
            mq.delete();
            movf = 0;
            mudf = 0;
        end else begin
            rd = rd_en && (mq.size() > 0);
            wr = wr_en && ((mq.size() < DEPTH) || rd);
            if (wr_en && !wr) movf = 1;
            if (rd_en && mq.size() == 0) mudf = 1;
            if (rd) mdout = mq.pop_front();
            if (wr) mq.push_back(din);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("m0_count", 32'(if0.count), 32'(mq.size()));
            chk("m0_empty", 32'(if0.empty), 32'(mq.size() == 0));
            chk("m0_full",  32'(if0.full),  32'(mq.size() == DEPTH));
            chk("m0_af",    32'(if0.almost_full),  32'(mq.size() >= AF));
            chk("m0_ae",    32'(if0.almost_empty), 32'(mq.size() <= AE));
            chk("m0_ovf",   32'(if0.overflow),  32'(movf));
            chk("m0_udf",   32'(if0.underflow), 32'(mudf));
            chk("m0_dout",  32'(if0.dout), 32'(mdout));
            chk("m1_count", 32'(if1.count), 32'(mq.size()));
            chk("m1_empty", 32'(if1.empty), 32'(mq.size() == 0));
            chk("m1_full",  32'(if1.full),  32'(mq.size() == DEPTH));
            chk("m1_af",    32'(if1.almost_full),  32'(mq.size() >= AF));
            chk("m1_ae",    32'(if1.almost_empty), 32'(mq.size() <= AE));
            chk("m1_ovf",   32'(if1.overflow),  32'(movf));
            chk("m1_udf",   32'(if1.underflow), 32'(mudf));
            if (mq.size() > 0) chk("m1_dout", 32'(if1.dout), 32'(mq[0]));
        end
    end

    task automatic cyc(input bit fl, input bit w, input logic [7:0] d, input bit r);
        flush = fl;
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] v1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst_n = 1'b0;
        cyc(0, 0, 8'h00, 0);
        cyc(0, 0, 8'h00, 0);
        rst_n = 1'b1;
        chk("rst_count", 32'(if0.count), 0);
        chk("rst_empty", 32'(if0.empty), 1);
        chk("rst_full",  32'(if0.full), 0);
        chk("rst_ae",    32'(if0.almost_empty), 1);
        chk("rst_af",    32'(if0.almost_full), 0);
        chk("rst_dout",  32'(if0.dout), 0);
        chk("rst_ovf",   32'(if0.overflow), 0);

        // Fill to full, then overflow.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, v1[i], 0);
            chk("t1_count", 32'(if0.count), 32'(i + 1));
            if (i == 2) chk("t1_af3", 32'(if0.almost_full), 1);
            if (i == 3) chk("t1_full4", 32'(if0.full), 1);
        end
        cyc(0, 1, 8'h99, 0);
        chk("t1_ovf", 32'(if0.overflow), 1);
        chk("t1_ovf_count", 32'(if0.count), 4);

        // Drain in standard mode, then underflow.
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 8'h00, 1);
            chk("t2_dout", 32'(if0.dout), 32'(v1[i]));
        end
        chk("t2_empty", 32'(if0.empty), 1);
        cyc(0, 0, 8'h00, 1);
        chk("t2_udf", 32'(if0.underflow), 1);
        chk("t2_hold", 32'(if0.dout), 32'h44);

        // Flush with simultaneous requests: requests ignored, dout kept.
        cyc(1, 1, 8'h77, 1);
        chk("fl_count", 32'(if0.count), 0);
        chk("fl_ovf",   32'(if0.overflow), 0);
        chk("fl_udf",   32'(if0.underflow), 0);
        chk("fl_dout",  32'(if0.dout), 32'h44);

        // Read+write while full, then sustained exchange across the wrap.
        for (int i = 0; i < 4; i++) cyc(0, 1, v1[i], 0);
        cyc(0, 1, 8'h55, 1);
        chk("t3_dout", 32'(if0.dout), 32'h11);
        chk("t3_count", 32'(if0.count), 4);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 8'(8'h60 + i), 1);
            if (i == 3) chk("t3_55", 32'(if0.dout), 32'h55);
            chk("t3_xcount", 32'(if0.count), 4);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1);
        chk("t3_last", 32'(if0.dout), 32'h69);
        chk("t3_empty", 32'(if0.empty), 1);

        // Read+write while empty: read rejected.
        cyc(0, 1, 8'hA5, 1);
        chk("t4_udf", 32'(if0.underflow), 1);
        chk("t4_count", 32'(if0.count), 1);
        chk("t4_hold", 32'(if0.dout), 32'h69);
        cyc(0, 0, 8'h00, 1);
        chk("t4_dout", 32'(if0.dout), 32'hA5);

        // FWFT presentation and pops.
        cyc(0, 1, 8'h01, 0);
        chk("t5_head1", 32'(if1.dout), 32'h01);
        chk("t5_nempty", 32'(if1.empty), 0);
        cyc(0, 0, 8'h00, 1);
        chk("t5_empty", 32'(if1.empty), 1);
        cyc(0, 1, 8'h02, 0);
        cyc(0, 1, 8'h03, 0);
        chk("t5_head2", 32'(if1.dout), 32'h02);
        cyc(0, 0, 8'h00, 1);
        chk("t5_head3", 32'(if1.dout), 32'h03);
        cyc(0, 0, 8'h00, 1);

        // Flush with 3 entries and both sticky flags set, then reset mid-fill.
        cyc(0, 1, 8'h0A, 0);
        cyc(0, 1, 8'h0B, 0);
        cyc(0, 1, 8'h0C, 0);
        cyc(0, 1, 8'h0D, 0);
        cyc(0, 1, 8'h0E, 0);
        cyc(0, 0, 8'h00, 1);
        chk("t6_pre_count", 32'(if0.count), 3);
        chk("t6_pre_flags", 32'({if0.overflow, if0.underflow}), 32'h3);
        chk("t6_pre_dout", 32'(if0.dout), 32'h0A);
        cyc(1, 0, 8'h00, 0);
        chk("t6_fl_count", 32'(if0.count), 0);
        chk("t6_fl_flags", 32'({if0.overflow, if0.underflow}), 0);
        chk("t6_fl_dout", 32'(if0.dout), 32'h0A);
        cyc(0, 1, 8'h21, 0);
        cyc(0, 1, 8'h22, 0);
        chk("t6_refill", 32'(if0.count), 2);
        rst_n = 1'b0;
        cyc(0, 1, 8'h33, 0);
        chk("t6_rst_count", 32'(if0.count), 0);
        chk("t6_rst_dout", 32'(if0.dout), 0);
        chk("t6_rst_empty", 32'(if0.empty), 1);
        rst_n = 1'b1;
        cyc(0, 0, 8'h00, 0);
        chk("t6_post_count", 32'(if0.count), 0);
        cyc(0, 1, 8'h5A, 0);
        cyc(0, 0, 8'h00, 1);
        chk("t6_post_dout", 32'(if0.dout), 32'h5A);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
